// File: rtl/sram_stream_reader_if.sv
// Bundle between sram_stream_reader and its neighbours:
// request/status, output stream and SRAM controller side.
interface sram_stream_reader_if;
  logic        start;
  logic [17:0] base_address;
  logic [17:0] word_count;
  logic        busy;
  logic        done;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        SRAM_ready;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n;
  logic [15:0] SRAM_write_data;
  logic [15:0] SRAM_read_data;

  modport master (
    output start,
    output base_address,
    output word_count,
    output out_ready,
    output SRAM_ready,
    output SRAM_read_data,
    input  busy,
    input  done,
    input  out_data,
    input  out_valid,
    input  SRAM_address,
    input  SRAM_we_n,
    input  SRAM_write_data
  );

  modport slave (
    input  start,
    input  base_address,
    input  word_count,
    input  out_ready,
    input  SRAM_ready,
    input  SRAM_read_data,
    output busy,
    output done,
    output out_data,
    output out_valid,
    output SRAM_address,
    output SRAM_we_n,
    output SRAM_write_data
  );
endinterface

// File: rtl/sram_stream_reader.sv
// Streams a block of SRAM words out on a valid/ready port,
// issuing reads against credit so returning data is never dropped.
module sram_stream_reader #(
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input logic Clock_50,
  input logic Resetn,
  sram_stream_reader_if.slave bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(READ_LATENCY + 1);
  localparam int OW = ((CW > IW) ? CW : IW) + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FINISH
  } state_t;

  state_t state;
  state_t state_nx;

  logic [17:0] addr_reg;
  logic [17:0] issue_left;
  logic [17:0] deliver_left;
  logic [17:0] sram_addr_q;

  logic [READ_LATENCY-1:0] tag;
  logic [READ_LATENCY-1:0] tag_nx;
  logic [IW-1:0] inflight;

  logic [15:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;

  logic [OW-1:0] occ;
  logic credit_ok;
  logic issue;
  logic push;
  logic pop;
  logic fifo_valid;
  logic start_ok;

  always_comb begin
    occ = OW'(fifo_count) + OW'(inflight);
    credit_ok = occ < OW'(FIFO_DEPTH);
    fifo_valid = fifo_count != '0;
    pop = fifo_valid && bus.out_ready;
    push = tag[READ_LATENCY-1];
    start_ok = (state == IDLE) && bus.start;
    issue = (state == ISSUE)
         && bus.SRAM_ready
         && (issue_left != '0)
         && credit_ok;
  end

  // tag[i] marks a read issued i+1 cycles ago
  always_comb begin
    tag_nx = tag << 1;
    tag_nx[0] = issue;
  end

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = (bus.word_count == '0) ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        if (issue_left == '0
            || (issue && issue_left == 18'd1)) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (deliver_left == '0) begin
          state_nx = FINISH;
        end
      end
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == ISSUE) || (state == DRAIN);
    bus.done = (state == FINISH);
    bus.SRAM_address = issue ? addr_reg : sram_addr_q;
    bus.SRAM_we_n = 1'b1;
    bus.SRAM_write_data = '0;
    bus.out_valid = fifo_valid;
    bus.out_data = fifo_valid ? mem[rd_ptr] : '0;
  end

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      addr_reg <= '0;
      issue_left <= '0;
      deliver_left <= '0;
      sram_addr_q <= '0;
    end else if (start_ok) begin
      addr_reg <= bus.base_address;
      issue_left <= bus.word_count;
      deliver_left <= bus.word_count;
    end else begin
      if (issue) begin
        addr_reg <= addr_reg + 18'd1;
        issue_left <= issue_left - 18'd1;
        sram_addr_q <= addr_reg;
      end
      if (pop) begin
        deliver_left <= deliver_left - 18'd1;
      end
    end
  end

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      tag <= '0;
      inflight <= '0;
    end else begin
      tag <= tag_nx;
      unique case ({issue, push})
        2'b10: inflight <= inflight + 1'b1;
        2'b01: inflight <= inflight - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.SRAM_read_data;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10: fifo_count <= fifo_count + 1'b1;
        2'b01: fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock_50) begin
    if (Resetn) begin
      assert (!(push && !pop && fifo_count == CW'(FIFO_DEPTH)));
    end
  end

endmodule
